gcd_req_arbiter: RTL and testbench

- Shares one GCD unit between NUM_REQ independent requesters using val/rdy handshakes on both sides.
- Round-robin arbitration; exactly one transaction in flight.
- Routes each GCD response back to the requester that issued it.
- Sits between the test sources/sinks (or client blocks) and the single GCD datapath instance.

---
 rtl/gcd_arb_pkg.sv | 20 ++
 rtl/gcd_rr_pick.sv | 33 +++
 rtl/gcd_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_gcd_req_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and sizing helpers for the GCD request arbiter.
// The optional statistics block in the top is enabled with GCD_ARB_STATS_EN.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    localparam int W_DEF     = 16;
    localparam int OPND_W    = W_DEF;
    localparam int MSG_W_DEF = 2 * W_DEF;

    // Width of a requester index; a single bit is kept even for tiny configurations.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: first asserted bit at or after ptr_i, wrapping.
module gcd_rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  val_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int          c;
            logic [IW-1:0] ci;
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!any_o && val_i[ci]) begin
                any_o       = 1'b1;
                grant_o[ci] = 1'b1;
                idx_o       = ci;
            end
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one GCD unit among NUM_REQ requesters, one transaction in flight, round-robin.
// Define GCD_ARB_STATS_EN to add per-requester completion and busy-cycle counters.
//
// Handshakes on every interface: a beat transfers on a rising edge where val and rdy
// are both high; val never depends combinationally on the same interface's rdy.
module gcd_req_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = W_DEF,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_val,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*2*W-1:0] req_msg,
    output logic [NUM_REQ-1:0]     resp_val,
    input  logic [NUM_REQ-1:0]     resp_rdy,
    output logic [W-1:0]           resp_msg,
    output logic                   gcd_req_val,
    input  logic                   gcd_req_rdy,
    output logic [2*W-1:0]         gcd_req_msg,
    input  logic                   gcd_resp_val,
    output logic                   gcd_resp_rdy,
    input  logic [W-1:0]           gcd_resp_msg,
    output logic                   busy,
    output arb_state_e             dbg_state,
    output logic [IW-1:0]          dbg_ptr
`ifdef GCD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  stat_done,
    output logic [31:0]            stat_busy
`endif
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [2*W-1:0]   opnd_q, opnd_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               resp_fire;

    gcd_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .val_i   (req_val),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign resp_fire = (state_q == WAIT) && gcd_resp_val && resp_rdy[owner_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            opnd_q  <= opnd_d;
        end
    end

    // The pointer moves only when a response completes, never on grant.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        opnd_d  = opnd_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    opnd_d  = req_msg[2*W*int'(pick_idx) +: 2*W];
                    owner_d = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (gcd_req_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (resp_fire) begin
                    ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_rdy is gated by reset so nothing can look accepted while reset is held.
    always_comb begin
        req_rdy      = '0;
        resp_val     = '0;
        resp_msg     = '0;
        gcd_req_val  = 1'b0;
        gcd_req_msg  = opnd_q;
        gcd_resp_rdy = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: req_rdy = pick_grant & {NUM_REQ{reset_n}};
            SEND: gcd_req_val = 1'b1;
            WAIT: begin
                resp_val[owner_q] = gcd_resp_val;
                resp_msg          = gcd_resp_msg;
                gcd_resp_rdy      = resp_rdy[owner_q];
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

`ifdef GCD_ARB_STATS_EN
    logic [15:0] done_cnt_q [NUM_REQ];
    logic [31:0] busy_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) done_cnt_q[i] <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (busy) busy_cnt_q <= busy_cnt_q + 32'd1;
            if (resp_fire) done_cnt_q[owner_q] <= done_cnt_q[owner_q] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_done[16*g +: 16] = done_cnt_q[g];
    end
    assign stat_busy = busy_cnt_q;
`endif

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter: behavioural GCD unit, scoreboard monitor on responses.
// Build with GCD_ARB_STATS_EN defined to also cover the statistics counters.
module tb_gcd_req_arbiter;
    import gcd_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int EW = W + 8;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req_val, req_rdy, resp_val, resp_rdy;
    logic [N*2*W-1:0] req_msg;
    logic [W-1:0]     resp_msg, gcd_resp_msg;
    logic             gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy, busy;
    logic [2*W-1:0]   gcd_req_msg;
    arb_state_e       dbg_state;
    logic [1:0]       dbg_ptr;
`ifdef GCD_ARB_STATS_EN
    logic [N*16-1:0]  stat_done;
    logic [31:0]      stat_busy;
    int               busy_cnt;
`endif

    int               n_vec, n_err;
    logic [EW-1:0]    exp_q[$];
    logic             stall_req, model_flush;

    // GCD unit model state
    logic             m_busy, m_rf, m_sf;
    int               m_cnt;
    logic [W-1:0]     m_res;

    gcd_req_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_msg (gcd_resp_msg),
        .busy         (busy),
        .dbg_state    (dbg_state),
        .dbg_ptr      (dbg_ptr)
`ifdef GCD_ARB_STATS_EN
        ,
        .stat_done    (stat_done),
        .stat_busy    (stat_busy)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic submit(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res);
        req_msg[2*W*i +: 2*W] = {a, b};
        req_val[i] = 1'b1;
        exp_q.push_back({8'(i), res});
    endtask

    // One clock; drops req_val for requesters whose handshake fired on this edge.
    task automatic tick();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = req_val & req_rdy;
        @(posedge clk);
        #1;
        req_val = req_val & ~fire;
    endtask

    task automatic wait_state(input arb_state_e s, input string name);
        for (int k = 0; k < 100 && dbg_state != s; k++) tick();
        check(name, 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && req_val == '0 && dbg_state == IDLE) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        model_flush = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n     = 1'b1;
        model_flush = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic run_four();
        submit(0, 16'd10, 16'd15, 16'd5);
        submit(1, 16'd8,  16'd14, 16'd2);
        submit(2, 16'd36, 16'd54, 16'd18);
        submit(3, 16'd9,  16'd12, 16'd3);
        wait_done("four_drain");
    endtask

    // ---------------- GCD unit model ----------------
    initial begin
        gcd_req_rdy  = 1'b0;
        gcd_resp_val = 1'b0;
        gcd_resp_msg = '0;
        m_busy = 1'b0;
        m_cnt  = 0;
        m_res  = '0;
        forever begin
            @(negedge clk);
            m_rf = gcd_req_val && gcd_req_rdy;
            m_sf = gcd_resp_val && gcd_resp_rdy;
            if (m_rf) m_res = gcd_fn(gcd_req_msg[2*W-1:W], gcd_req_msg[W-1:0]);
            @(posedge clk);
            #1;
            if (model_flush) begin
                m_busy       = 1'b0;
                m_cnt        = 0;
                gcd_resp_val = 1'b0;
            end else begin
                if (m_rf) begin
                    m_busy = 1'b1;
                    m_cnt  = 2;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        gcd_resp_val = 1'b1;
                        gcd_resp_msg = m_res;
                    end
                end
                if (m_sf) begin
                    gcd_resp_val = 1'b0;
                    m_busy       = 1'b0;
                end
            end
            gcd_req_rdy = !m_busy && !stall_req;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset_n && resp_val != '0) begin
            logic [EW-1:0] h;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: resp_val=%b with nothing pending", resp_val);
            end else begin
                h = exp_q[0];
                check("resp_owner", 32'(resp_val), 32'(1) << h[W +: 8]);
                if ((resp_val & resp_rdy) != '0) begin
                    void'(exp_q.pop_front());
                    check("resp_msg", 32'(resp_msg), 32'(h[W-1:0]));
                end
            end
        end
    end

`ifdef GCD_ARB_STATS_EN
    always @(negedge clk) begin
        if (!reset_n) busy_cnt = 0;
        else if (busy) busy_cnt++;
    end
`endif

    // ---------------- directed sequence ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        req_val = '0;
        req_msg = '0;
        resp_rdy = '1;
        stall_req = 1'b0;
        model_flush = 1'b0;
        reset_n = 1'b0;

        // Reset values, with requests pending to show req_rdy stays low
        req_val = 4'b0101;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy",      32'(req_rdy), 0);
        check("rst_resp_val",     32'(resp_val), 0);
        check("rst_gcd_req_val",  32'(gcd_req_val), 0);
        check("rst_gcd_resp_rdy", 32'(gcd_resp_rdy), 0);
        check("rst_busy",         32'(busy), 0);
        check("rst_ptr",          32'(dbg_ptr), 0);
        req_val = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, latency and pointer advance
        submit(0, 16'd10, 16'd15, 16'd5);
        tick();
        check("t1_gcd_req_val_c1", 32'(gcd_req_val), 1);
        check("t1_req_rdy_low",    32'(req_rdy), 0);
        check("t1_gcd_req_msg",    gcd_req_msg, {16'd10, 16'd15});
        check("t1_busy",           32'(busy), 1);
        wait_done("t1_drain");
        check("t1_ptr", 32'(dbg_ptr), 1);

        // Four simultaneous requests from ptr=0, pointer wraps after requester 3
        do_reset();
        check("t2_ptr_start", 32'(dbg_ptr), 0);
        run_four();
        check("t2_ptr_wrap", 32'(dbg_ptr), 0);
`ifdef GCD_ARB_STATS_EN
        run_four();
        for (int i = 0; i < N; i++) check("stat_done", 32'(stat_done[16*i +: 16]), 2);
        check("stat_busy", stat_busy, 32'(busy_cnt));
`endif

        // Rotation: with ptr=2, requester 3 beats requester 0
        submit(0, 16'd12, 16'd8, 16'd4);
        wait_done("t3_a");
        submit(1, 16'd7, 16'd21, 16'd7);
        wait_done("t3_b");
        check("t3_ptr2", 32'(dbg_ptr), 2);
        submit(3, 16'd100, 16'd75, 16'd25);
        submit(0, 16'd48, 16'd18, 16'd6);
        wait_done("t3_c");
        check("t3_ptr1", 32'(dbg_ptr), 1);

        // Back-pressure on the GCD request and the response side
        stall_req   = 1'b1;
        resp_rdy[1] = 1'b0;
        submit(1, 16'd8, 16'd14, 16'd2);
        tick();
        check("t4_send", 32'(dbg_state), 32'(SEND));
        submit(2, 16'd9, 16'd12, 16'd3);
        repeat (5) begin
            @(negedge clk);
            check("t4_msg_stable", gcd_req_msg, {16'd8, 16'd14});
            check("t4_req_rdy_low", 32'(req_rdy), 0);
            check("t4_gcd_req_val", 32'(gcd_req_val), 1);
        end
        stall_req = 1'b0;
        wait_state(WAIT, "t4_wait");
        for (int k = 0; k < 20 && !gcd_resp_val; k++) tick();
        repeat (4) begin
            @(negedge clk);
            check("t4_gcd_resp_rdy_low", 32'(gcd_resp_rdy), 0);
            check("t4_ptr_held", 32'(dbg_ptr), 1);
            check("t4_still_wait", 32'(dbg_state), 32'(WAIT));
        end
        @(posedge clk);
        #1;
        resp_rdy[1] = 1'b1;
        wait_done("t4_drain");
        check("t4_ptr3", 32'(dbg_ptr), 3);

        // Asynchronous reset in WAIT drops the transaction
        resp_rdy[0] = 1'b0;
        submit(0, 16'd12, 16'd18, 16'd6);
        wait_state(WAIT, "t5_wait");
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_busy",         32'(busy), 0);
        check("t5_resp_val",     32'(resp_val), 0);
        check("t5_gcd_resp_rdy", 32'(gcd_resp_rdy), 0);
        check("t5_gcd_req_val",  32'(gcd_req_val), 0);
        check("t5_req_rdy",      32'(req_rdy), 0);
        check("t5_ptr",          32'(dbg_ptr), 0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy = '1;
        repeat (4) begin
            @(negedge clk);
            check("t5_late_resp_val", 32'(resp_val), 0);
            check("t5_late_gcd_rdy",  32'(gcd_resp_rdy), 0);
        end
        model_flush = 1'b1;
        @(negedge clk);
        model_flush = 1'b0;
        @(posedge clk);
        #1;
        submit(0, 16'd36, 16'd54, 16'd18);
        wait_done("t5_drain");
        check("t5_ptr_after", 32'(dbg_ptr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
